maclaurin_arbiter: RTL and testbench

// Shares one Maclaurin-series evaluation engine (start/x/result/done, active-high engine reset) among
// N_REQ requesters. Round-robin arbitration; per job: reset engine, pulse start, wait for done.

---
 rtl/maclaurin_arbiter_if.sv | 30 +++
 rtl/maclaurin_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_maclaurin_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maclaurin_arbiter_if.sv
// Client and engine signal bundle for maclaurin_arbiter.
// The arbiter connects through the slave modport. Clients and the engine model use the master modport.
interface maclaurin_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int X_W   = 16,
    parameter int R_W   = 18
);
    logic [N_REQ-1:0]     reqValid;
    logic [N_REQ*X_W-1:0] reqX;
    logic [N_REQ-1:0]     reqReady;
    logic [N_REQ-1:0]     rspValid;
    logic [R_W-1:0]       rspR;
    logic                 rspErr;
    logic                 engRst;
    logic                 engStart;
    logic [X_W-1:0]       engX;
    logic [R_W-1:0]       engR;
    logic                 engDone;
    logic                 busy;

    modport slave (
        input  reqValid, reqX, engR, engDone,
        output reqReady, rspValid, rspR, rspErr, engRst, engStart, engX, busy
    );

    modport master (
        output reqValid, reqX, engR, engDone,
        input  reqReady, rspValid, rspR, rspErr, engRst, engStart, engX, busy
    );
endinterface

// File: rtl/maclaurin_arbiter.sv
// Round-robin sharing of one Maclaurin-series engine among N_REQ clients.
// Each job resets the engine, pulses start, and waits for done or a timeout.
// The module then returns the result to the client that was granted.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | engine held in reset, scanning requests from ptr with wrap
// S_RESET | engine reset for one cycle, reqReady pulse to the granted client
// S_START | engine released, start pulse, timeout counter cleared
// S_WAIT  | counting cycles until engDone or until TIMEOUT cycles have elapsed
// S_RESP  | one-cycle response pulse, rr pointer moves past the granted client
module maclaurin_arbiter #(
    parameter int N_REQ   = 4,
    parameter int X_W     = 16,
    parameter int R_W     = 18,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    maclaurin_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gnt_q, gnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [R_W-1:0]   rsp_r_q, rsp_r_d;
    logic             rsp_err_q, rsp_err_d;
    logic             eng_rst_q, eng_rst_d;
    logic             eng_start_q, eng_start_d;
    logic [X_W-1:0]   eng_x_q, eng_x_d;
    logic             busy_q, busy_d;

    logic             pick_found;
    logic [PW-1:0]    pick_idx;
    logic [PW:0]      scan;
    logic [X_W-1:0]   sel_x;

    // Round-robin pick: the first pending request at or after ptr, wrapping past N_REQ-1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan >= (PW+1)'(N_REQ)) begin
                scan = scan - (PW+1)'(N_REQ);
            end
            if (!pick_found && bus.reqValid[scan[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[PW-1:0];
            end
        end
    end

    // Operand mux for the candidate requester.
    always_comb begin
        sel_x = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == PW'(i)) begin
                sel_x = bus.reqX[i*X_W +: X_W];
            end
        end
    end

    // Next-state and next-output logic. All outputs are registered alongside the state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        eng_x_d     = eng_x_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_r_d     = '0;
        rsp_err_d   = 1'b0;
        eng_rst_d   = 1'b1;
        eng_start_d = 1'b0;
        busy_d      = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (pick_found) begin
                    gnt_d                 = pick_idx;
                    eng_x_d               = sel_x;
                    req_ready_d[pick_idx] = 1'b1;
                    busy_d                = 1'b1;
                    state_d               = S_RESET;
                end
            end
            S_RESET: begin
                eng_rst_d   = 1'b0;
                eng_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = S_START;
            end
            S_START: begin
                eng_rst_d = 1'b0;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                eng_rst_d = 1'b0;
                // A done seen on the final WAIT cycle still counts as a real result.
                if (bus.engDone) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_r_d            = bus.engR;
                    state_d            = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_err_d          = 1'b1;
                    state_d            = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                busy_d  = 1'b0;
                ptr_d   = (gnt_q == PW'(N_REQ - 1)) ? '0 : gnt_q + PW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any job in flight and keeps the engine in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_r_q     <= '0;
            rsp_err_q   <= 1'b0;
            eng_rst_q   <= 1'b1;
            eng_start_q <= 1'b0;
            eng_x_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
            rsp_err_q   <= rsp_err_d;
            eng_rst_q   <= eng_rst_d;
            eng_start_q <= eng_start_d;
            eng_x_q     <= eng_x_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.reqReady = req_ready_q;
    assign bus.rspValid = rsp_valid_q;
    assign bus.rspR     = rsp_r_q;
    assign bus.rspErr   = rsp_err_q;
    assign bus.engRst   = eng_rst_q;
    assign bus.engStart = eng_start_q;
    assign bus.engX     = eng_x_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_maclaurin_arbiter.sv
// Directed bench for maclaurin_arbiter with a latency-programmable engine stub.
// The stub raises done L cycles after it samples engStart, and returns {2'b01, engX} ^ 18'h00003.
module tb_maclaurin_arbiter;
    localparam int N  = 4;
    localparam int XW = 16;
    localparam int RW = 18;
    localparam int TO = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int   stub_lat = 0;
    int   stub_cnt;
    logic stub_done;

    int   start_cnt   = 0;
    int   rstfall_cnt = 0;
    int   rsp_cnt     = 0;
    logic eng_rst_prev = 1'b1;

    maclaurin_arbiter_if #(.N_REQ(N), .X_W(XW), .R_W(RW)) bus ();

    maclaurin_arbiter #(.N_REQ(N), .X_W(XW), .R_W(RW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RW-1:0] stub_result(input logic [XW-1:0] x);
        return {2'b01, x} ^ 18'h00003;
    endfunction

    assign bus.engDone = stub_done;
    assign bus.engR    = stub_result(bus.engX);

    // Engine stub. Latency 0 means the stub never raises done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_done <= 1'b0;
            stub_cnt  <= 0;
        end else if (bus.engRst) begin
            stub_done <= 1'b0;
            stub_cnt  <= 0;
        end else if (bus.engStart) begin
            stub_cnt <= stub_lat;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_done <= 1'b1;
        end
    end

    // Count engine pulses and responses, sampled on the inactive clock edge.
    always @(negedge clk) begin
        if (bus.engStart === 1'b1) start_cnt++;
        if (eng_rst_prev === 1'b1 && bus.engRst === 1'b0) rstfall_cnt++;
        eng_rst_prev = bus.engRst;
        if (bus.rspValid !== '0) rsp_cnt++;
    end

    task automatic set_req(input int i, input logic [XW-1:0] x);
        bus.reqX[i*XW +: XW] = x;
        bus.reqValid[i]      = 1'b1;
    endtask

    task automatic drop_req(input int i);
        bus.reqValid[i] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.reqValid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits for a reqReady pulse. On an expired budget v stays 0, so the caller's compare fails.
    task automatic wait_ready(output logic [N-1:0] v, output int t);
        v = '0;
        t = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.reqReady !== '0) begin
                v = bus.reqReady;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output logic [N-1:0] v, output logic [RW-1:0] r, output logic e,
                            output int t, output bit saw_ready);
        v = '0;
        r = '0;
        e = 1'b0;
        t = -1;
        saw_ready = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.reqReady !== '0) saw_ready = 1'b1;
            if (bus.rspValid !== '0) begin
                v = bus.rspValid;
                r = bus.rspR;
                e = bus.rspErr;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.reqValid = '0;
        bus.reqX     = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.engRst !== 1'b1) begin
            errors++; $display("FAIL reset_engrst got %b exp 1", bus.engRst);
        end
        checks++;
        if ({bus.engStart, bus.busy, bus.reqReady, bus.rspValid, bus.rspErr} !== '0) begin
            errors++; $display("FAIL reset_ctrl got start=%b busy=%b rdy=%b vld=%b err=%b exp all 0",
                               bus.engStart, bus.busy, bus.reqReady, bus.rspValid, bus.rspErr);
        end
        checks++;
        if ({bus.rspR, bus.engX} !== '0) begin
            errors++; $display("FAIL reset_data got rspR=%h engX=%h exp 0", bus.rspR, bus.engX);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.engRst, bus.busy, bus.reqReady} !== {1'b1, 1'b0, 4'b0000}) begin
            errors++; $display("FAIL idle_after_reset got engRst=%b busy=%b rdy=%b exp 1 0 0000",
                               bus.engRst, bus.busy, bus.reqReady);
        end
    endtask

    task automatic test_single();
        logic [N-1:0]  v;
        logic [RW-1:0] r;
        logic          e;
        int            t_acc, t_rsp;
        bit            sr;
        stub_lat = 10;
        @(negedge clk);
        set_req(0, 16'h8000);
        wait_ready(v, t_acc);
        checks++;
        if (v !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", v); end
        checks++;
        if (bus.engX !== 16'h8000) begin errors++; $display("FAIL single_engx got %h exp 8000", bus.engX); end
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", bus.busy); end
        drop_req(0);
        @(negedge clk);
        checks++;
        if ({bus.reqReady, bus.engStart, bus.engRst} !== {4'b0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL single_start got rdy=%b start=%b engRst=%b exp 0000 1 0",
                               bus.reqReady, bus.engStart, bus.engRst);
        end
        wait_rsp(v, r, e, t_rsp, sr);
        checks++;
        if (v !== 4'b0001) begin errors++; $display("FAIL single_rspvalid got %b exp 0001", v); end
        checks++;
        if (r !== 18'h18003) begin errors++; $display("FAIL single_rspr got %h exp 18003", r); end
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL single_rsperr got %b exp 0", e); end
        checks++;
        if (t_rsp - t_acc !== 13) begin
            errors++; $display("FAIL single_latency got %0d exp 13", t_rsp - t_acc);
        end
        @(negedge clk);
        checks++;
        if ({bus.rspValid, bus.busy} !== 5'b0) begin
            errors++; $display("FAIL single_rsp_pulse got vld=%b busy=%b exp 0000 0", bus.rspValid, bus.busy);
        end
    endtask

    task automatic test_all_four();
        logic [N-1:0]  v, exp_oh;
        logic [RW-1:0] r;
        logic [XW-1:0] xi;
        logic          e;
        int            t_acc, t_rsp, t_prev;
        bit            sr;
        pulse_reset();
        stub_lat = 5;
        for (int i = 0; i < N; i++) begin
            xi = XW'(i) << 12;
            set_req(i, xi);
        end
        t_prev = -1;
        for (int i = 0; i < N; i++) begin
            exp_oh = N'(1) << i;
            xi     = XW'(i) << 12;
            wait_ready(v, t_acc);
            checks++;
            if (v !== exp_oh) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, v, exp_oh); end
            if (i > 0) begin
                checks++;
                if (t_acc - t_prev !== 2) begin
                    errors++; $display("FAIL rr_b2b_gap[%0d] got %0d exp 2", i, t_acc - t_prev);
                end
            end
            drop_req(i);
            wait_rsp(v, r, e, t_rsp, sr);
            t_prev = t_rsp;
            checks++;
            if ({v, r, e, sr} !== {exp_oh, stub_result(xi), 1'b0, 1'b0}) begin
                errors++; $display("FAIL rr_rsp[%0d] got vld=%b r=%h err=%b overlap=%b exp %b %h 0 0",
                                   i, v, r, e, sr, exp_oh, stub_result(xi));
            end
        end
    endtask

    task automatic test_alternate();
        logic [N-1:0]  v, exp_oh;
        logic [RW-1:0] r;
        logic [XW-1:0] xe;
        logic          e;
        int            t_acc, t_rsp;
        bit            sr;
        int            seq [4] = '{3, 1, 3, 1};
        stub_lat = 3;
        @(negedge clk);
        set_req(1, 16'h0101);
        wait_ready(v, t_acc);
        checks++;
        if (v !== 4'b0010) begin errors++; $display("FAIL alt_first got %b exp 0010", v); end
        set_req(3, 16'h0303);
        wait_rsp(v, r, e, t_rsp, sr);
        checks++;
        if ({v, r} !== {4'b0010, stub_result(16'h0101)}) begin
            errors++; $display("FAIL alt_first_rsp got %b %h exp 0010 %h", v, r, stub_result(16'h0101));
        end
        for (int k = 0; k < 4; k++) begin
            exp_oh = N'(1) << seq[k];
            xe     = (seq[k] == 3) ? 16'h0303 : 16'h0101;
            wait_ready(v, t_acc);
            checks++;
            if (v !== exp_oh) begin errors++; $display("FAIL alt_grant[%0d] got %b exp %b", k, v, exp_oh); end
            wait_rsp(v, r, e, t_rsp, sr);
            checks++;
            if ({v, r, e} !== {exp_oh, stub_result(xe), 1'b0}) begin
                errors++; $display("FAIL alt_rsp[%0d] got %b %h %b exp %b %h 0", k, v, r, e, exp_oh, stub_result(xe));
            end
        end
        bus.reqValid = '0;
        repeat (2) @(negedge clk);
    endtask

    // WAIT lasts TIMEOUT cycles after the single START cycle, so the response arrives TO+1 cycles
    // after the cycle in which engStart is high. A done on that last WAIT cycle takes priority over the timeout.
    task automatic test_timeout();
        logic [N-1:0]  v;
        logic [RW-1:0] r, exp_r;
        logic          e;
        int            t_acc, t_start, t_rsp;
        bit            sr;
        int            lat  [3] = '{0, TO - 1, TO};
        logic          xerr [3] = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            stub_lat = lat[k];
            exp_r    = xerr[k] ? '0 : stub_result(16'h1234);
            @(negedge clk);
            set_req(2, 16'h1234);
            wait_ready(v, t_acc);
            checks++;
            if (v !== 4'b0100) begin errors++; $display("FAIL to_grant[%0d] got %b exp 0100", k, v); end
            drop_req(2);
            @(negedge clk);
            t_start = cyc;
            checks++;
            if (bus.engStart !== 1'b1) begin errors++; $display("FAIL to_start[%0d] got %b exp 1", k, bus.engStart); end
            wait_rsp(v, r, e, t_rsp, sr);
            checks++;
            if ({v, e, r} !== {4'b0100, xerr[k], exp_r}) begin
                errors++; $display("FAIL to_rsp[%0d] got vld=%b err=%b r=%h exp 0100 %b %h", k, v, e, r, xerr[k], exp_r);
            end
            checks++;
            if (t_rsp - t_start !== TO + 1) begin
                errors++; $display("FAIL to_latency[%0d] got %0d exp %0d", k, t_rsp - t_start, TO + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0]  v;
        logic [RW-1:0] r;
        logic          e;
        int            t_acc, t_rsp, n0;
        bit            sr;
        stub_lat = 4;
        @(negedge clk);
        set_req(0, 16'h4000);
        wait_ready(v, t_acc);
        drop_req(0);
        wait_rsp(v, r, e, t_rsp, sr);
        checks++;
        if (v !== 4'b0001) begin errors++; $display("FAIL mid_job1 got %b exp 0001", v); end
        stub_lat = 20;
        @(negedge clk);
        set_req(1, 16'h5000);
        wait_ready(v, t_acc);
        checks++;
        if (v !== 4'b0010) begin errors++; $display("FAIL mid_job2_grant got %b exp 0010", v); end
        drop_req(1);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.engRst, bus.engStart, bus.busy} !== 3'b100) begin
            errors++; $display("FAIL mid_rst_ctrl got engRst=%b start=%b busy=%b exp 1 0 0",
                               bus.engRst, bus.engStart, bus.busy);
        end
        checks++;
        if ({bus.reqReady, bus.rspValid, bus.rspErr, bus.rspR, bus.engX} !== '0) begin
            errors++; $display("FAIL mid_rst_data got rdy=%b vld=%b err=%b r=%h x=%h exp 0",
                               bus.reqReady, bus.rspValid, bus.rspErr, bus.rspR, bus.engX);
        end
        n0 = rsp_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (rsp_cnt !== n0) begin errors++; $display("FAIL mid_rst_no_rsp got %0d exp %0d", rsp_cnt, n0); end
        stub_lat = 2;
        set_req(0, 16'h0600);
        set_req(2, 16'h0700);
        wait_ready(v, t_acc);
        checks++;
        if (v !== 4'b0001) begin errors++; $display("FAIL mid_regrant got %b exp 0001", v); end
        drop_req(0);
        wait_rsp(v, r, e, t_rsp, sr);
        checks++;
        if ({v, r, e} !== {4'b0001, stub_result(16'h0600), 1'b0}) begin
            errors++; $display("FAIL mid_regrant_rsp got %b %h %b exp 0001 %h 0", v, r, e, stub_result(16'h0600));
        end
        wait_ready(v, t_acc);
        checks++;
        if (v !== 4'b0100) begin errors++; $display("FAIL mid_next_grant got %b exp 0100", v); end
        drop_req(2);
        wait_rsp(v, r, e, t_rsp, sr);
        checks++;
        if ({v, r} !== {4'b0100, stub_result(16'h0700)}) begin
            errors++; $display("FAIL mid_next_rsp got %b %h exp 0100 %h", v, r, stub_result(16'h0700));
        end
    endtask

    task automatic test_corner();
        logic [N-1:0]  v, exp_oh;
        logic [RW-1:0] r;
        logic          e;
        int            t_acc, t_rsp, s0, f0;
        bit            sr;
        logic [XW-1:0] xs [2] = '{16'hFFFF, 16'h0000};
        int            rq [2] = '{3, 0};
        stub_lat = 1;
        for (int k = 0; k < 2; k++) begin
            exp_oh = N'(1) << rq[k];
            @(negedge clk);
            s0 = start_cnt;
            f0 = rstfall_cnt;
            set_req(rq[k], xs[k]);
            wait_ready(v, t_acc);
            checks++;
            if ({v, bus.engX} !== {exp_oh, xs[k]}) begin
                errors++; $display("FAIL corner_engx[%0d] got %b %h exp %b %h", k, v, bus.engX, exp_oh, xs[k]);
            end
            drop_req(rq[k]);
            wait_rsp(v, r, e, t_rsp, sr);
            checks++;
            if ({v, r, e, bus.engX} !== {exp_oh, stub_result(xs[k]), 1'b0, xs[k]}) begin
                errors++; $display("FAIL corner_rsp[%0d] got %b %h %b x=%h exp %b %h 0 %h",
                                   k, v, r, e, bus.engX, exp_oh, stub_result(xs[k]), xs[k]);
            end
            checks++;
            if (t_rsp - t_acc !== 4) begin
                errors++; $display("FAIL corner_latency[%0d] got %0d exp 4", k, t_rsp - t_acc);
            end
            repeat (2) @(negedge clk);
            checks++;
            if ((start_cnt - s0 !== 1) || (rstfall_cnt - f0 !== 1)) begin
                errors++; $display("FAIL corner_pulses[%0d] got start=%0d rstfall=%0d exp 1 1",
                                   k, start_cnt - s0, rstfall_cnt - f0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.reqValid = '0;
        bus.reqX     = '0;
        test_reset();
        test_single();
        test_all_four();
        test_alternate();
        test_timeout();
        test_reset_mid();
        test_corner();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
